// File: rtl/nios2_gen2_cpu_div_cell_pkg.sv
// Shared types and constants for the Nios II/gen2 multi-cycle divider cell.
// Default width, FSM state encoding and the divide-by-zero quotient pattern.
package nios2_gen2_cpu_div_cell_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_CNT_W  = $clog2(DIV_DATA_W);

    localparam logic [DIV_DATA_W-1:0] DIV_BY_ZERO_QUOT = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } div_state_e;

    // An operand contributes a sign only for the signed (div) form.
    function automatic logic div_operand_neg(input logic is_signed, input logic sign_bit);
        return is_signed & sign_bit;
    endfunction

endpackage

// File: rtl/nios2_gen2_cpu_div_cell_if.sv
// E-stage request / M-stage result bundle between the CPU pipeline and the divider.
// The pipeline side is the master, the divider is the slave.
interface nios2_gen2_cpu_div_cell_if
    import nios2_gen2_cpu_div_cell_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
);
    logic [DATA_W-1:0] E_src1;
    logic [DATA_W-1:0] E_src2;
    logic              E_div_start;
    logic              E_div_signed;
    logic              E_div_kill;

    logic              M_div_busy;
    logic              M_div_done;
    logic [DATA_W-1:0] M_div_quot;
    logic [DATA_W-1:0] M_div_rem;
    logic              M_div_by_zero;

    modport master (
        output E_src1, E_src2, E_div_start, E_div_signed, E_div_kill,
        input  M_div_busy, M_div_done, M_div_quot, M_div_rem, M_div_by_zero
    );

    modport slave (
        input  E_src1, E_src2, E_div_start, E_div_signed, E_div_kill,
        output M_div_busy, M_div_done, M_div_quot, M_div_rem, M_div_by_zero
    );

endinterface

// File: rtl/nios2_gen2_cpu_div_cell_step.sv
// One combinational radix-2 restoring division step.
// Shifts the next dividend bit into the partial remainder and trial-subtracts the divisor.
module nios2_div_step
    import nios2_gen2_cpu_div_cell_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic [DATA_W-1:0] i_rem,
    input  logic              i_dvd_msb,
    input  logic [DATA_W-1:0] i_dvsr,
    output logic [DATA_W-1:0] o_rem,
    output logic              o_qbit
);

    logic [DATA_W:0] w_shift;
    logic [DATA_W:0] w_diff;

    assign w_shift = {i_rem, i_dvd_msb};
    assign w_diff  = w_shift - {1'b0, i_dvsr};

    // The incoming remainder is always below the divisor, so the trial difference
    // fits in DATA_W bits when it is non-negative; its top bit is therefore a pure borrow.
    assign o_qbit = ~w_diff[DATA_W];
    assign o_rem  = o_qbit ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];

endmodule

// File: rtl/nios2_gen2_cpu_div_cell.sv
// Fixed-latency radix-2 restoring divider for div/divu: DATA_W iteration cycles
// plus one sign-fix cycle, results registered with a one-cycle done pulse.
module nios2_gen2_cpu_div_cell
    import nios2_gen2_cpu_div_cell_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    nios2_gen2_cpu_div_cell_if.slave   bus
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] QUOT_BY_ZERO = {DATA_W{1'b1}};

    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic neg);
        return neg ? (~v + DATA_W'(1)) : v;
    endfunction

    div_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_dvd;
    logic [DATA_W-1:0] r_dvsr;
    logic [DATA_W-1:0] r_rem;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_dvsr_zero;

    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_quot_out;
    logic [DATA_W-1:0] r_rem_out;
    logic              r_by_zero;

    logic              w_neg_a;
    logic              w_neg_b;
    logic [DATA_W-1:0] w_step_rem;
    logic              w_step_qbit;
    logic [DATA_W-1:0] w_quot_fix;
    logic [DATA_W-1:0] w_rem_fix;

    assign w_neg_a = div_operand_neg(bus.E_div_signed, bus.E_src1[DATA_W-1]);
    assign w_neg_b = div_operand_neg(bus.E_div_signed, bus.E_src2[DATA_W-1]);

    nios2_div_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .i_rem     (r_rem),
        .i_dvd_msb (r_dvd[DATA_W-1]),
        .i_dvsr    (r_dvsr),
        .o_rem     (w_step_rem),
        .o_qbit    (w_step_qbit)
    );

    // r_dvd doubles as the quotient register: each step shifts a dividend bit out
    // of the top and a quotient bit into the bottom.
    assign w_quot_fix = r_dvsr_zero ? QUOT_BY_ZERO : cond_neg(r_dvd, r_neg_q);
    // With a zero divisor the remainder magnitude is |dividend|, so restoring the
    // dividend sign reproduces the original dividend exactly (including the most negative value).
    assign w_rem_fix  = cond_neg(r_rem, r_neg_r);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_dvd       <= '0;
            r_dvsr      <= '0;
            r_rem       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dvsr_zero <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quot_out  <= '0;
            r_rem_out   <= '0;
            r_by_zero   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    // Kill wins over a simultaneous start.
                    if (bus.E_div_start && !bus.E_div_kill) begin
                        r_dvd       <= cond_neg(bus.E_src1, w_neg_a);
                        r_dvsr      <= cond_neg(bus.E_src2, w_neg_b);
                        r_neg_q     <= w_neg_a ^ w_neg_b;
                        r_neg_r     <= w_neg_a;
                        r_dvsr_zero <= (bus.E_src2 == '0);
                        r_rem       <= '0;
                        r_cnt       <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    if (bus.E_div_kill) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_rem <= w_step_rem;
                        r_dvd <= {r_dvd[DATA_W-2:0], w_step_qbit};
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_LAST) begin
                            r_state <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                    if (!bus.E_div_kill) begin
                        r_quot_out <= w_quot_fix;
                        r_rem_out  <= w_rem_fix;
                        r_by_zero  <= r_dvsr_zero;
                        r_done     <= 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.M_div_busy    = r_busy;
    assign bus.M_div_done    = r_done;
    assign bus.M_div_quot    = r_quot_out;
    assign bus.M_div_rem     = r_rem_out;
    assign bus.M_div_by_zero = r_by_zero;

endmodule

// File: tb/tb_nios2_gen2_cpu_div_cell.sv
// Directed bench for the multi-cycle divider: latency, signed/unsigned results,
// divide-by-zero, ignored restart, kill and asynchronous reset.
module tb_nios2_gen2_cpu_div_cell;

    logic clk;
    logic reset_n;
    int   errors;
    int   checks;

    nios2_gen2_cpu_div_cell_if #(.DATA_W(32)) bus ();

    nios2_gen2_cpu_div_cell #(
        .DATA_W (32)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge, i.e. into the next cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.E_src1       = '0;
        bus.E_src2       = '0;
        bus.E_div_start  = 1'b0;
        bus.E_div_signed = 1'b0;
        bus.E_div_kill   = 1'b0;
    endtask

    // Present a start in the current cycle (cycle 0) and move into cycle 1.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        bus.E_src1       = a;
        bus.E_src2       = b;
        bus.E_div_signed = sgn;
        bus.E_div_start  = 1'b1;
        tick();
        bus.E_div_start  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        #2;
        checks++; if (bus.M_div_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.M_div_busy); end
        checks++; if (bus.M_div_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", bus.M_div_done); end
        checks++; if (bus.M_div_quot !== 32'h0) begin errors++; $display("FAIL reset_quot got=%h want=0", bus.M_div_quot); end
        checks++; if (bus.M_div_rem !== 32'h0) begin errors++; $display("FAIL reset_rem got=%h want=0", bus.M_div_rem); end
        checks++; if (bus.M_div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_by_zero got=%b want=0", bus.M_div_by_zero); end
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_divu_basic();
        int bad_busy;
        bad_busy = 0;
        issue(32'd100, 32'd7, 1'b0);
        for (int c = 1; c <= 33; c++) begin
            if (bus.M_div_busy !== 1'b1 || bus.M_div_done !== 1'b0) bad_busy++;
            tick();
        end
        checks++; if (bad_busy != 0) begin errors++; $display("FAIL divu_busy_window bad_cycles=%0d want=0", bad_busy); end
        checks++; if (bus.M_div_done !== 1'b1) begin errors++; $display("FAIL divu_done_c34 got=%b want=1", bus.M_div_done); end
        checks++; if (bus.M_div_busy !== 1'b0) begin errors++; $display("FAIL divu_busy_c34 got=%b want=0", bus.M_div_busy); end
        checks++; if (bus.M_div_quot !== 32'd14) begin errors++; $display("FAIL divu_quot got=%h want=%h", bus.M_div_quot, 32'd14); end
        checks++; if (bus.M_div_rem !== 32'd2) begin errors++; $display("FAIL divu_rem got=%h want=%h", bus.M_div_rem, 32'd2); end
        checks++; if (bus.M_div_by_zero !== 1'b0) begin errors++; $display("FAIL divu_by_zero got=%b want=0", bus.M_div_by_zero); end
        tick();
        checks++; if (bus.M_div_done !== 1'b0) begin errors++; $display("FAIL divu_done_single got=%b want=0", bus.M_div_done); end
        checks++; if (bus.M_div_quot !== 32'd14) begin errors++; $display("FAIL divu_quot_held got=%h want=%h", bus.M_div_quot, 32'd14); end
    endtask

    task automatic test_signed_and_zero();
        logic [31:0] ta [6];
        logic [31:0] tb [6];
        logic        ts [6];
        logic [31:0] eq [6];
        logic [31:0] er [6];
        logic        ez [6];
        ta[0] = 32'hFFFF_FFF9; tb[0] = 32'd2;          ts[0] = 1'b1; eq[0] = 32'hFFFF_FFFD; er[0] = 32'hFFFF_FFFF; ez[0] = 1'b0;
        ta[1] = 32'd7;         tb[1] = 32'hFFFF_FFFE;  ts[1] = 1'b1; eq[1] = 32'hFFFF_FFFD; er[1] = 32'd1;         ez[1] = 1'b0;
        ta[2] = 32'h8000_0000; tb[2] = 32'hFFFF_FFFF;  ts[2] = 1'b1; eq[2] = 32'h8000_0000; er[2] = 32'd0;         ez[2] = 1'b0;
        ta[3] = 32'd5;         tb[3] = 32'd0;          ts[3] = 1'b0; eq[3] = 32'hFFFF_FFFF; er[3] = 32'd5;         ez[3] = 1'b1;
        ta[4] = 32'hFFFF_FFF9; tb[4] = 32'd0;          ts[4] = 1'b1; eq[4] = 32'hFFFF_FFFF; er[4] = 32'hFFFF_FFF9; ez[4] = 1'b1;
        ta[5] = 32'hFFFF_FFF9; tb[5] = 32'd2;          ts[5] = 1'b0; eq[5] = 32'h7FFF_FFFC; er[5] = 32'd1;         ez[5] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            issue(ta[i], tb[i], ts[i]);
            repeat (33) tick();
            checks++; if (bus.M_div_done !== 1'b1) begin errors++; $display("FAIL sdiv%0d_done got=%b want=1", i, bus.M_div_done); end
            checks++; if (bus.M_div_quot !== eq[i]) begin errors++; $display("FAIL sdiv%0d_quot got=%h want=%h", i, bus.M_div_quot, eq[i]); end
            checks++; if (bus.M_div_rem !== er[i]) begin errors++; $display("FAIL sdiv%0d_rem got=%h want=%h", i, bus.M_div_rem, er[i]); end
            checks++; if (bus.M_div_by_zero !== ez[i]) begin errors++; $display("FAIL sdiv%0d_by_zero got=%b want=%b", i, bus.M_div_by_zero, ez[i]); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        issue(32'd100, 32'd7, 1'b0);
        for (int c = 1; c <= 33; c++) begin
            if (c == 10) begin
                bus.E_src1      = 32'd9;
                bus.E_src2      = 32'd3;
                bus.E_div_start = 1'b1;
            end else begin
                bus.E_div_start = 1'b0;
            end
            tick();
        end
        checks++; if (bus.M_div_done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got=%b want=1", bus.M_div_done); end
        checks++; if (bus.M_div_quot !== 32'd14) begin errors++; $display("FAIL b2b_first_quot got=%h want=%h", bus.M_div_quot, 32'd14); end
        checks++; if (bus.M_div_rem !== 32'd2) begin errors++; $display("FAIL b2b_first_rem got=%h want=%h", bus.M_div_rem, 32'd2); end
        issue(32'd9, 32'd3, 1'b0);
        for (int c = 35; c <= 67; c++) tick();
        checks++; if (bus.M_div_done !== 1'b1) begin errors++; $display("FAIL b2b_second_done got=%b want=1", bus.M_div_done); end
        checks++; if (bus.M_div_quot !== 32'd3) begin errors++; $display("FAIL b2b_second_quot got=%h want=%h", bus.M_div_quot, 32'd3); end
        checks++; if (bus.M_div_rem !== 32'd0) begin errors++; $display("FAIL b2b_second_rem got=%h want=%h", bus.M_div_rem, 32'd0); end
        tick();
    endtask

    task automatic test_kill();
        int stray;
        issue(32'd10, 32'd3, 1'b0);
        repeat (19) tick();
        bus.E_div_kill = 1'b1;
        tick();
        bus.E_div_kill = 1'b0;
        checks++; if (bus.M_div_busy !== 1'b0) begin errors++; $display("FAIL kill_busy_c21 got=%b want=0", bus.M_div_busy); end
        stray = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.M_div_done !== 1'b0 || bus.M_div_busy !== 1'b0) stray++;
            tick();
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL kill_no_done stray_cycles=%0d want=0", stray); end
        checks++; if (bus.M_div_quot !== 32'd3) begin errors++; $display("FAIL kill_quot_held got=%h want=%h", bus.M_div_quot, 32'd3); end
        checks++; if (bus.M_div_rem !== 32'd0) begin errors++; $display("FAIL kill_rem_held got=%h want=%h", bus.M_div_rem, 32'd0); end
        bus.E_src1      = 32'd50;
        bus.E_src2      = 32'd5;
        bus.E_div_start = 1'b1;
        bus.E_div_kill  = 1'b1;
        tick();
        bus.E_div_start = 1'b0;
        bus.E_div_kill  = 1'b0;
        checks++; if (bus.M_div_busy !== 1'b0) begin errors++; $display("FAIL kill_start_busy got=%b want=0", bus.M_div_busy); end
        stray = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.M_div_done !== 1'b0 || bus.M_div_busy !== 1'b0) stray++;
            tick();
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL kill_start_dropped stray_cycles=%0d want=0", stray); end
    endtask

    task automatic test_reset_mid();
        issue(32'd100, 32'd7, 1'b0);
        repeat (14) tick();
        reset_n = 1'b0;
        #1;
        checks++; if (bus.M_div_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b want=0", bus.M_div_busy); end
        checks++; if (bus.M_div_done !== 1'b0) begin errors++; $display("FAIL rstmid_done got=%b want=0", bus.M_div_done); end
        checks++; if (bus.M_div_quot !== 32'h0) begin errors++; $display("FAIL rstmid_quot got=%h want=0", bus.M_div_quot); end
        checks++; if (bus.M_div_rem !== 32'h0) begin errors++; $display("FAIL rstmid_rem got=%h want=0", bus.M_div_rem); end
        checks++; if (bus.M_div_by_zero !== 1'b0) begin errors++; $display("FAIL rstmid_by_zero got=%b want=0", bus.M_div_by_zero); end
        tick();
        reset_n = 1'b1;
        tick();
        issue(32'd10, 32'd3, 1'b0);
        repeat (32) tick();
        checks++; if (bus.M_div_done !== 1'b0 || bus.M_div_busy !== 1'b1) begin errors++; $display("FAIL rstmid_c33 done=%b busy=%b want done=0 busy=1", bus.M_div_done, bus.M_div_busy); end
        tick();
        checks++; if (bus.M_div_done !== 1'b1) begin errors++; $display("FAIL rstmid_done_c34 got=%b want=1", bus.M_div_done); end
        checks++; if (bus.M_div_quot !== 32'd3) begin errors++; $display("FAIL rstmid_quot_after got=%h want=%h", bus.M_div_quot, 32'd3); end
        checks++; if (bus.M_div_rem !== 32'd1) begin errors++; $display("FAIL rstmid_rem_after got=%h want=%h", bus.M_div_rem, 32'd1); end
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_divu_basic();
        test_signed_and_zero();
        test_back_to_back();
        test_kill();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nios2_gen2_cpu_div_cell.md
# nios2_gen2_cpu_div_cell

Multi-cycle 32-bit integer divider for the Nios II/gen2 CPU execute/memory stages. It complements the partial-product multiplier cell and implements `div` and `divu`. One divide is accepted from E-stage operands at a time. The divider uses a radix-2 restoring algorithm with fixed latency, then returns quotient and remainder with a one-cycle done pulse for the pipeline stall logic.

## Interface
- DATA_W, 32: operand and result width; must be even and ≥ 4.
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- E_src1  in  DATA_W  dividend; sampled only on an accepted start.
- E_src2  in  DATA_W  divisor; sampled only on an accepted start.
- E_div_start  in  1  request a divide; accepted only when not busy.
- E_div_signed  in  1  operation type: 1 = `div`, 0 = `divu`; sampled with start.
- E_div_kill  in  1  pipeline flush; aborts an in-flight divide.
- M_div_busy  out  1  a divide is in progress.
- M_div_done  out  1  one-cycle pulse; results are valid.
- M_div_quot  out  DATA_W  quotient; held until the next done.
- M_div_rem  out  DATA_W  remainder; held until the next done.
- M_div_by_zero  out  1  the last completed divide had divisor 0; held with the results.

## Operation
- **States:**
  - IDLE
  - ITER: DATA_W cycles
  - FIX: 1 cycle
- **IDLE + E_div_start:**
  - Latch the signs: neg_q = signed & (src1 sign ^ src2 sign); neg_r = signed & src1 sign.
  - Latch operand magnitudes: two's-complement absolute value when signed, raw when unsigned.
  - Clear the partial remainder (DATA_W+1 bits), set count = 0, go to ITER.
- **ITER step:**
  - rem' = {rem, dividend MSB}; dividend shifts left.
  - If rem' ≥ divisor: rem = rem' − divisor and shift a 1 into the quotient; otherwise rem = rem' and shift in 0.
  - count increments; at count = DATA_W−1 go to FIX.
- **FIX:**
  - Apply negation: quotient negated if neg_q, remainder negated if neg_r.
  - Register M_div_quot, M_div_rem and M_div_by_zero; pulse M_div_done; return to IDLE.
- **Divide by zero:**
  - Iterate normally; no early exit and no latency change.
  - The algorithm naturally yields magnitude quotient all-ones and remainder = |dividend|.
  - FIX forces quot = all-ones and rem = the original dividend (unsigned and signed alike), and sets M_div_by_zero = 1.
- **Signed overflow (−2^(DATA_W−1) / −1):** result is quot = 0x80000000 and rem = 0. This falls out of the magnitude path with wrap-around and needs no special case.
- **Sign rule:** remainder sign follows the dividend; quotient truncates toward zero.
- **E_div_kill:**
  - In ITER or FIX: return to IDLE next edge with no done pulse; result registers are unchanged.
  - In IDLE: kill has priority over a simultaneous start, so the start is dropped.
- **E_div_start while busy:** ignored; the operands are not resampled.

## Timing
- **Reset:** asynchronous assertion forces IDLE and drives every output to 0 (busy, done, quot, rem, by_zero); internal count and operands are also 0. Reset mid-operation discards the divide.
- **Latency (start sampled at the end of cycle N):**
  - M_div_busy = 1 in cycles N+1 … N+DATA_W+1.
  - M_div_done = 1 only in cycle N+DATA_W+2 (N+34 for 32-bit); busy = 0 in that cycle.
- **Back-to-back:** a new start is accepted in the done cycle, so throughput is one divide per DATA_W+2 cycles.
- **Registered outputs:** all outputs are registered; no combinational path from any input to any output.

## Structure
- **Shared package:**
  - state enum {IDLE, ITER, FIX}
  - DIV_CNT_W = $clog2(DATA_W)
  - DIV_BY_ZERO_QUOT constant (all-ones)
- **Sub-module `nios2_div_step`:** one combinational restoring step.
  - Inputs: rem, dividend MSB, divisor.
  - Outputs: next rem, quotient bit.
  - Top level holds the FSM, counter, sign handling and output registers.

## Test plan
- divu 100 / 7, start at cycle 0 → done in cycle 34 with quot = 14, rem = 2, by_zero = 0; busy high in cycles 1–33.
- div 0xFFFFFFF9 (−7) / 2 → quot = 0xFFFFFFFD (−3), rem = 0xFFFFFFFF (−1); div 7 / 0xFFFFFFFE → quot = 0xFFFFFFFD, rem = 1.
- div 0x80000000 / 0xFFFFFFFF → quot = 0x80000000, rem = 0; divu 5 / 0 → quot = 0xFFFFFFFF, rem = 5, by_zero = 1, done in cycle 34.
- divu 100 / 7 with a second start (9 / 3) in cycle 10 → the second start is ignored and cycle 34 shows quot = 14; 9 / 3 issued in cycle 34 → done in cycle 68 with quot = 3, rem = 0.
- E_div_kill in cycle 20 of a divide → IDLE in cycle 21, no done pulse, previous results held; start and kill in the same IDLE cycle → nothing is accepted.
- reset_n low in cycle 15 mid-divide → all outputs 0 immediately; after release, a fresh divu 10 / 3 gives quot = 3, rem = 1 with nominal latency.
